mfp_ahb_frame_pacer: RTL and testbench
======================================

# mfp_ahb_frame_pacer

AHB-Lite slave peripheral on the MIPSfpga peripheral bus that generates the main-loop frame tick in hardware, replacing busy-wait delay loops. A programmable down-counter, advanced by a prescaled tick, expires every PERIOD ticks. Each expiry sets a sticky flag, counts missed frames (overruns) and can raise an interrupt line to the core.

## Interface
Parameters:
- PRESCALE, 3, HCLK cycles per count tick (≥1); 3 keeps tick units equal to one basic delay-loop iteration
- DEFAULT_PERIOD, 416666, PERIOD reset value (40 Hz at 50 MHz)
- OVR_WIDTH, 8, overrun counter width; saturating

Ports:
- HCLK  in  1  system clock; single clock domain
- HRESETn  in  1  reset, asynchronous, active-low
- HADDR  in  4  register index (address phase)
- HTRANS  in  2  AHB transfer type
- HWDATA  in  32  write data (data phase)
- HWRITE  in  1  write strobe (address phase)
- HSEL  in  1  slave select
- HRDATA  out  32  registered read data; reset 0
- IRQ  out  1  registered interrupt request, level, active-high; reset 0

## Operation
- Write path: HADDR/HWRITE/HSEL/HTRANS delayed one cycle to align with HWDATA. we_d = HTRANS_d≠IDLE & HSEL_d & HWRITE_d.
- Registers, selected by index:
  - CTRL: bit0 EN, bit1 IRQEN, bit2 ONESHOT. Reset 0.
  - PERIOD: 32-bit reload value. Reset DEFAULT_PERIOD.
  - COUNT: current down-counter. Reset 0. A write loads COUNT and clears the prescaler.
  - STATUS: bit0 EXP (sticky); bits[8+OVR_WIDTH-1:8] OVR. Reset 0.
    - Write with bit0=1 clears EXP.
    - Write with bit1=1 clears OVR.
- EN 0→1 write (edge E0): prescaler←0, COUNT←PERIOD. EN 1→1 rewrite changes nothing else.
- Prescaler runs only while EN=1. Tick = EN & prescaler==PRESCALE-1; prescaler wraps to 0 on the tick.
- On tick:
  - COUNT==1: expire. EXP←1. If EXP was already 1, OVR←OVR+1, saturating at all-ones. Then:
    - ONESHOT=0: COUNT←PERIOD.
    - ONESHOT=1: COUNT←0 and EN←0.
  - COUNT>1: COUNT←COUNT-1.
  - COUNT==0: hold, never expire. PERIOD=0 therefore disables expiry.
- PERIOD writes never disturb COUNT; the new value takes effect at the next reload.
- IRQ register ← EXP & IRQEN each cycle.

Simultaneous events:
- COUNT write and tick in the same cycle: the write wins; no decrement, no expiry.
- STATUS clear and expiry in the same cycle: EXP=1 afterward. OVR is not incremented; if the OVR clear bit is set, OVR=0.
- CTRL write EN=0 and tick in the same cycle: EN=0 wins; no expiry.

Read and reset:
- Read: HRDATA ← register selected by the undelayed HADDR, every cycle. Unmapped index reads 0. Unused CTRL/STATUS bits read 0.
- Reset mid-count returns all state to its reset values immediately (asynchronous).

## Timing
- Read latency: 1 HCLK; data valid in the AHB data phase.
- Write takes effect at the edge ending the data phase (E0).
- From EN write at E0 with PERIOD=N≥1:
  - First expiry at edge E0+PRESCALE·N; EXP readable the following cycle.
  - IRQ asserts at E0+PRESCALE·N+1.
  - Subsequent expiries every PRESCALE·N edges, with no drift.
- IRQ deasserts one edge after the edge on which EXP is cleared or IRQEN is cleared.

## Structure
- mfp_ahb_const.vh gains:
  - H_PACER_CTRL_IONUM, H_PACER_PERIOD_IONUM, H_PACER_COUNT_IONUM, H_PACER_STATUS_IONUM
  - Field masks for EN/IRQEN/ONESHOT and EXP/OVR-clear bits
  - The peripheral's HSEL decode entry
- The address-phase delay uses the existing delaybyx (X=1, WIDTH=8).
- One sub-module: mfp_pacer_core. It holds the prescaler, down-counter, expiry/overrun logic and the IRQ register. It is driven by decoded write strobes from the AHB wrapper.

## Test plan
- Reset → HRDATA=0, IRQ=0. Read PERIOD=416666, COUNT=0, CTRL=0, STATUS=0.
- PRESCALE=3, PERIOD=4, write CTRL=0x3 at E0 → COUNT reads 3 after E3. EXP=1 at E12. IRQ=1 at E13. Next expiry at E24.
- Never clear EXP, run 300 periods → OVR saturates at 255 and does not wrap. STATUS write 0x3 → EXP=0, OVR=0, IRQ=0 one edge later.
- ONESHOT=1, PERIOD=2 → a single expiry at E0+6, then EN=0 and COUNT=0, with no further expiries over 100 cycles.
- Write COUNT=5 on the same cycle as a pending COUNT==1 tick → no expiry; COUNT reads 5. PERIOD=0 with EN=1 → EXP stays 0 indefinitely.
- STATUS clear on the exact expiry edge → EXP=1 and OVR unchanged. Assert HRESETn low mid-count → all registers and outputs return to their reset values without a clock edge.

Source files
------------

// File: rtl/mfp_ahb_frame_pacer_pkg.sv
// Shared register map, field masks and helpers for the frame pacer peripheral.
package mfp_ahb_frame_pacer_pkg;

  // Register indices on the peripheral bus (HADDR register index)
  localparam logic [3:0] H_PACER_CTRL_IONUM   = 4'd0;
  localparam logic [3:0] H_PACER_PERIOD_IONUM = 4'd1;
  localparam logic [3:0] H_PACER_COUNT_IONUM  = 4'd2;
  localparam logic [3:0] H_PACER_STATUS_IONUM = 4'd3;

  // CTRL field masks
  localparam logic [31:0] PACER_CTRL_EN_MASK      = 32'h0000_0001;
  localparam logic [31:0] PACER_CTRL_IRQEN_MASK   = 32'h0000_0002;
  localparam logic [31:0] PACER_CTRL_ONESHOT_MASK = 32'h0000_0004;

  // STATUS write-one-to-clear masks
  localparam logic [31:0] PACER_STATUS_EXP_CLR_MASK = 32'h0000_0001;
  localparam logic [31:0] PACER_STATUS_OVR_CLR_MASK = 32'h0000_0002;

  // Bit position of the overrun field inside STATUS
  localparam int PACER_OVR_LSB = 8;

  localparam logic [1:0] HTRANS_IDLE = 2'b00;

  typedef struct packed {
    logic oneshot;
    logic irqen;
    logic en;
  } pacer_ctrl_t;

  // Saturating increment used by the overrun counter
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max);
    if (value >= max) begin
      return max;
    end else begin
      return value + 32'd1;
    end
  endfunction

endpackage

// File: rtl/mfp_pacer_core.sv
// Frame pacer core: prescaler, reload down-counter, sticky expiry, saturating
// overrun counter and the registered interrupt request.
module mfp_pacer_core
  import mfp_ahb_frame_pacer_pkg::*;
#(
  parameter int PRESCALE       = 3,
  parameter int DEFAULT_PERIOD = 416666,
  parameter int OVR_WIDTH      = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_ctrl,
  input  logic                 wr_period,
  input  logic                 wr_count,
  input  logic                 wr_status,
  input  logic [31:0]          wdata,
  output pacer_ctrl_t          ctrl,
  output logic [31:0]          period,
  output logic [31:0]          count,
  output logic                 exp,
  output logic [OVR_WIDTH-1:0] ovr,
  output logic                 irq
);

  localparam int PSC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);
  localparam logic [31:0] OVR_MAX = 32'({OVR_WIDTH{1'b1}});

  pacer_ctrl_t          ctrl_r, ctrl_n;
  logic [31:0]          period_r, period_n;
  logic [31:0]          count_r, count_n;
  logic [PSC_W-1:0]     psc_r, psc_n;
  logic                 exp_r, exp_n;
  logic [OVR_WIDTH-1:0] ovr_r, ovr_n;
  logic                 irq_r;
  logic                 tick_s, tick_ok_s, expire_s, status_clr_s;

  assign tick_s = ctrl_r.en && (psc_r == PSC_LAST);
  // A COUNT write or a CTRL write that drops EN overrides the tick this cycle
  assign tick_ok_s = tick_s && !wr_count && !(wr_ctrl && !wdata[0]);
  assign status_clr_s = wr_status &&
                        ((wdata & (PACER_STATUS_EXP_CLR_MASK | PACER_STATUS_OVR_CLR_MASK)) != 32'd0);

  // Next-state computation for all pacer state with write-over-tick priority
  always_comb begin
    ctrl_n   = ctrl_r;
    period_n = period_r;
    count_n  = count_r;
    psc_n    = psc_r;
    exp_n    = exp_r;
    ovr_n    = ovr_r;
    expire_s = 1'b0;

    if (tick_s) begin
      psc_n = '0;
    end else if (ctrl_r.en) begin
      psc_n = psc_r + PSC_W'(1);
    end else begin
      psc_n = psc_r;
    end

    if (tick_ok_s) begin
      if (count_r == 32'd1) begin
        expire_s = 1'b1;
        if (ctrl_r.oneshot) begin
          count_n   = 32'd0;
          ctrl_n.en = 1'b0;
        end else begin
          count_n = period_r;
        end
      end else if (count_r != 32'd0) begin
        count_n = count_r - 32'd1;
      end else begin
        count_n = count_r;
      end
    end else begin
      count_n = count_r;
    end

    if (wr_ctrl) begin
      ctrl_n.en      = (wdata & PACER_CTRL_EN_MASK) != 32'd0;
      ctrl_n.irqen   = (wdata & PACER_CTRL_IRQEN_MASK) != 32'd0;
      ctrl_n.oneshot = (wdata & PACER_CTRL_ONESHOT_MASK) != 32'd0;
      // Only the enabling edge restarts the frame; EN 1->1 leaves timing alone
      if (ctrl_n.en && !ctrl_r.en) begin
        psc_n   = '0;
        count_n = period_r;
      end else begin
        psc_n = psc_n;
      end
    end else begin
      ctrl_n = ctrl_n;
    end

    if (wr_period) begin
      period_n = wdata;
    end else begin
      period_n = period_r;
    end

    if (wr_count) begin
      count_n = wdata;
      psc_n   = '0;
    end else begin
      count_n = count_n;
    end

    if (expire_s) begin
      exp_n = 1'b1;
      if (exp_r && !status_clr_s) begin
        ovr_n = OVR_WIDTH'(sat_inc(32'(ovr_r), OVR_MAX));
      end else begin
        ovr_n = ovr_r;
      end
    end else if (wr_status && ((wdata & PACER_STATUS_EXP_CLR_MASK) != 32'd0)) begin
      exp_n = 1'b0;
    end else begin
      exp_n = exp_r;
    end

    if (wr_status && ((wdata & PACER_STATUS_OVR_CLR_MASK) != 32'd0)) begin
      ovr_n = '0;
    end else begin
      ovr_n = ovr_n;
    end
  end

  // State registers for control, counter, prescaler, status and IRQ
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_r   <= '0;
      period_r <= 32'(DEFAULT_PERIOD);
      count_r  <= 32'd0;
      psc_r    <= '0;
      exp_r    <= 1'b0;
      ovr_r    <= '0;
      irq_r    <= 1'b0;
    end else begin
      ctrl_r   <= ctrl_n;
      period_r <= period_n;
      count_r  <= count_n;
      psc_r    <= psc_n;
      exp_r    <= exp_n;
      ovr_r    <= ovr_n;
      irq_r    <= exp_r & ctrl_r.irqen;
    end
  end

  assign ctrl   = ctrl_r;
  assign period = period_r;
  assign count  = count_r;
  assign exp    = exp_r;
  assign ovr    = ovr_r;
  assign irq    = irq_r;

endmodule

// File: rtl/mfp_ahb_frame_pacer.sv
// AHB-Lite wrapper for the frame pacer: aligns the address phase with write
// data, decodes register write strobes and registers read data.
module mfp_ahb_frame_pacer
  import mfp_ahb_frame_pacer_pkg::*;
#(
  parameter int PRESCALE       = 3,
  parameter int DEFAULT_PERIOD = 416666,
  parameter int OVR_WIDTH      = 8
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [3:0]  HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [31:0] HWDATA,
  input  logic        HWRITE,
  input  logic        HSEL,
  output logic [31:0] HRDATA,
  output logic        IRQ
);

  logic [3:0]           haddr_d;
  logic [1:0]           htrans_d;
  logic                 hwrite_d, hsel_d;
  logic                 we_d;
  logic [31:0]          rdata_s;
  logic [31:0]          hrdata_r;
  pacer_ctrl_t          ctrl;
  logic [31:0]          period, count;
  logic                 exp;
  logic [OVR_WIDTH-1:0] ovr;

  // One-cycle delay of the address-phase controls so they line up with HWDATA
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      {haddr_d, hwrite_d, hsel_d, htrans_d} <= 8'd0;
    end else begin
      {haddr_d, hwrite_d, hsel_d, htrans_d} <= {HADDR, HWRITE, HSEL, HTRANS};
    end
  end

  assign we_d = (htrans_d != HTRANS_IDLE) && hsel_d && hwrite_d;

  mfp_pacer_core #(
    .PRESCALE       (PRESCALE),
    .DEFAULT_PERIOD (DEFAULT_PERIOD),
    .OVR_WIDTH      (OVR_WIDTH)
  ) u_core (
    .clk       (HCLK),
    .rst_n     (HRESETn),
    .wr_ctrl   (we_d && (haddr_d == H_PACER_CTRL_IONUM)),
    .wr_period (we_d && (haddr_d == H_PACER_PERIOD_IONUM)),
    .wr_count  (we_d && (haddr_d == H_PACER_COUNT_IONUM)),
    .wr_status (we_d && (haddr_d == H_PACER_STATUS_IONUM)),
    .wdata     (HWDATA),
    .ctrl      (ctrl),
    .period    (period),
    .count     (count),
    .exp       (exp),
    .ovr       (ovr),
    .irq       (IRQ)
  );

  // Read mux on the undelayed address; unmapped indices and unused bits read 0
  always_comb begin
    rdata_s = 32'd0;
    case (HADDR)
      H_PACER_CTRL_IONUM:   rdata_s = {29'd0, ctrl.oneshot, ctrl.irqen, ctrl.en};
      H_PACER_PERIOD_IONUM: rdata_s = period;
      H_PACER_COUNT_IONUM:  rdata_s = count;
      H_PACER_STATUS_IONUM: begin
        rdata_s[0] = exp;
        rdata_s[PACER_OVR_LSB +: OVR_WIDTH] = ovr;
      end
      default:              rdata_s = 32'd0;
    endcase
  end

  // Registered read data, presented in the AHB data phase
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      hrdata_r <= 32'd0;
    end else begin
      hrdata_r <= rdata_s;
    end
  end

  assign HRDATA = hrdata_r;

endmodule

// File: tb/tb_mfp_ahb_frame_pacer.sv
// Directed testbench for mfp_ahb_frame_pacer with hand-computed expectations.
module tb_mfp_ahb_frame_pacer;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic [3:0]  HADDR = 4'd0;
  logic [1:0]  HTRANS = 2'b00;
  logic [31:0] HWDATA = 32'd0;
  logic        HWRITE = 1'b0;
  logic        HSEL = 1'b0;
  logic [31:0] HRDATA;
  logic        IRQ;

  int total = 0;
  int bad = 0;
  logic [31:0] rd;

  localparam logic [3:0] R_CTRL = 4'd0, R_PERIOD = 4'd1, R_COUNT = 4'd2, R_STATUS = 4'd3;

  mfp_ahb_frame_pacer #(.PRESCALE(3), .DEFAULT_PERIOD(416666), .OVR_WIDTH(8)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS), .HWDATA(HWDATA),
    .HWRITE(HWRITE), .HSEL(HSEL), .HRDATA(HRDATA), .IRQ(IRQ)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  // Address phase then data phase; the write lands on the edge ending the data phase
  task automatic ahb_write(input logic [3:0] idx, input logic [31:0] data);
    HADDR = idx; HWRITE = 1'b1; HSEL = 1'b1; HTRANS = 2'b10;
    edges(1);
    HWRITE = 1'b0; HSEL = 1'b0; HTRANS = 2'b00; HWDATA = data;
    edges(1);
  endtask

  // One-edge read: returns register contents as they were just before that edge
  task automatic ahb_read(input logic [3:0] idx, output logic [31:0] data);
    HADDR = idx; HWRITE = 1'b0; HSEL = 1'b1; HTRANS = 2'b10;
    edges(1);
    data = HRDATA;
    HSEL = 1'b0; HTRANS = 2'b00;
  endtask

  initial begin
    // Reset state
    edges(3);
    check("rst_hrdata", HRDATA, 32'd0);
    check("rst_irq", {31'd0, IRQ}, 32'd0);
    HRESETn = 1'b1;
    edges(1);
    ahb_read(R_PERIOD, rd); check("rst_period", rd, 32'd416666);
    ahb_read(R_COUNT, rd);  check("rst_count", rd, 32'd0);
    ahb_read(R_CTRL, rd);   check("rst_ctrl", rd, 32'd0);
    ahb_read(R_STATUS, rd); check("rst_status", rd, 32'd0);
    ahb_read(4'd9, rd);     check("unmapped", rd, 32'd0);

    // Periodic run, PERIOD=4, CTRL=EN|IRQEN at E0
    ahb_write(R_PERIOD, 32'd4);
    ahb_write(R_CTRL, 32'h3);              // E0
    edges(3);
    ahb_read(R_COUNT, rd);  check("count_after_e3", rd, 32'd3);       // edge E4
    edges(8);                                                           // E12
    check("irq_before", {31'd0, IRQ}, 32'd0);
    ahb_read(R_STATUS, rd); check("exp_e12", rd, 32'h1);              // edge E13
    check("irq_e13", {31'd0, IRQ}, 32'd1);
    edges(10);                                                          // E23
    ahb_read(R_STATUS, rd); check("pre_second", rd, 32'h1);           // edge E24
    ahb_read(R_STATUS, rd); check("ovr_e24", rd, 32'h101);            // edge E25
    ahb_read(R_CTRL, rd);   check("ctrl_rb", rd, 32'h3);

    // Overrun saturation, then clear both
    edges(3600);
    ahb_read(R_STATUS, rd); check("ovr_sat", rd, 32'hFF01);
    ahb_write(R_CTRL, 32'h2);
    ahb_write(R_STATUS, 32'h3);            // E0
    check("irq_at_clear", {31'd0, IRQ}, 32'd1);
    edges(1);
    check("irq_after_clear", {31'd0, IRQ}, 32'd0);
    ahb_read(R_STATUS, rd); check("status_cleared", rd, 32'h0);

    // One-shot, PERIOD=2
    ahb_write(R_PERIOD, 32'd2);
    ahb_write(R_CTRL, 32'h7);              // E0
    edges(5);
    ahb_read(R_STATUS, rd); check("os_pre", rd, 32'h0);               // edge E6
    ahb_read(R_STATUS, rd); check("os_exp", rd, 32'h1);               // edge E7
    check("os_irq", {31'd0, IRQ}, 32'd1);
    ahb_read(R_CTRL, rd);   check("os_en_off", rd, 32'h6);
    ahb_read(R_COUNT, rd);  check("os_count0", rd, 32'd0);
    ahb_write(R_STATUS, 32'h1);
    edges(100);
    ahb_read(R_STATUS, rd); check("os_no_more", rd, 32'h0);
    ahb_read(R_COUNT, rd);  check("os_count_hold", rd, 32'd0);

    // COUNT write on the same edge as a COUNT==1 tick
    ahb_write(R_PERIOD, 32'd4);
    ahb_write(R_CTRL, 32'h1);              // E0
    edges(10);
    ahb_write(R_COUNT, 32'd5);             // lands on E12
    ahb_read(R_COUNT, rd);  check("cw_count5", rd, 32'd5);
    ahb_read(R_STATUS, rd); check("cw_no_exp", rd, 32'h0);

    // PERIOD=0 disables expiry
    ahb_write(R_CTRL, 32'h0);
    ahb_write(R_PERIOD, 32'd0);
    ahb_write(R_STATUS, 32'h3);
    ahb_write(R_CTRL, 32'h1);
    edges(50);
    ahb_read(R_STATUS, rd); check("p0_no_exp", rd, 32'h0);
    ahb_read(R_COUNT, rd);  check("p0_count", rd, 32'd0);

    // STATUS clear on the exact expiry edge
    ahb_write(R_CTRL, 32'h0);
    ahb_write(R_PERIOD, 32'd4);
    ahb_write(R_CTRL, 32'h1);              // E0
    edges(22);
    ahb_write(R_STATUS, 32'h1);            // lands on E24
    ahb_read(R_STATUS, rd); check("clr_on_exp", rd, 32'h1);

    // Asynchronous reset mid-count
    ahb_write(R_CTRL, 32'h3);
    edges(1);
    check("pre_rst_irq", {31'd0, IRQ}, 32'd1);
    ahb_read(R_PERIOD, rd); check("pre_rst_period", rd, 32'd4);
    #2;
    HRESETn = 1'b0;
    #1;
    check("async_hrdata", HRDATA, 32'd0);
    check("async_irq", {31'd0, IRQ}, 32'd0);
    edges(1);
    HRESETn = 1'b1;
    ahb_read(R_PERIOD, rd); check("post_rst_period", rd, 32'd416666);
    ahb_read(R_COUNT, rd);  check("post_rst_count", rd, 32'd0);
    ahb_read(R_CTRL, rd);   check("post_rst_ctrl", rd, 32'd0);
    ahb_read(R_STATUS, rd); check("post_rst_status", rd, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
